// File: rtl/sensor_frame_rx.sv
// sensor_frame_rx
//   Serial deframer for 4-bit sensor samples. A frame on sdata is one bit per
//   sample_en tick: start (0), DATA_W data bits MSB first, even parity, stop (1).
//   Good frames update the held sensor_input word, pulse sample_valid and bump
//   a wrapping good-frame counter. Bad frames pulse an error strobe and leave
//   sensor_input untouched.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   sample_en     in   bit-rate tick; sdata is only looked at when high
//   sdata         in   serial line, idle high
//   sensor_input  out  last good sample (held)
//   sample_valid  out  one-cycle pulse, sensor_input just updated
//   parity_err    out  one-cycle pulse, frame dropped on parity mismatch
//   frame_err     out  one-cycle pulse, frame dropped on stop bit = 0
//   sample_count  out  count of good frames, wraps modulo 2^CNT_W
module sensor_frame_rx #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              sdata,
  output logic [DATA_W-1:0] sensor_input,
  output logic              sample_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic [CNT_W-1:0]  sample_count
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    data_d    = data_q;
    count_d   = count_q;
    // Strobes default low so each one lasts exactly one cycle.
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (sample_en) begin
      case (state_q)
        IDLE: begin
          if (!sdata) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          // Shift in at the LSB so the first data bit ends up as MSB.
          shift_d   = {shift_q[DATA_W-2:0], sdata};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = sdata;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A bad stop bit outranks a parity mismatch.
          if (!sdata) begin
            ferr_d = 1'b1;
          end else if (^{shift_q, parity_q}) begin
            perr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      data_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      data_q    <= data_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign sensor_input = data_q;
  assign sample_valid = valid_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Directed bench for sensor_frame_rx: one task per scenario, inline checks.
module tb_sensor_frame_rx;

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic       sdata;
  logic [3:0] sensor_input;
  logic       sample_valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] sample_count;

  int vec;
  int miss;

  // Strobe-high cycle counters, sampled on the falling edge.
  int valid_seen;
  int perr_seen;
  int ferr_seen;
  int multi_seen;

  sensor_frame_rx #(.DATA_W(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .sdata        (sdata),
    .sensor_input (sensor_input),
    .sample_valid (sample_valid),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) valid_seen++;
    if (parity_err === 1'b1) perr_seen++;
    if (frame_err === 1'b1) ferr_seen++;
    if ((32'(sample_valid) + 32'(parity_err) + 32'(frame_err)) > 1) multi_seen++;
  end

  // Called at a falling edge; presents one bit with a single-cycle tick,
  // then idles 'gap' cycles. Returns at a falling edge.
  task automatic drive_bit(input logic b, input int gap);
    sdata     = b;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic par, input logic stp, input int gap);
    drive_bit(1'b0, gap);
    for (int i = 3; i >= 0; i--) drive_bit(d[i], gap);
    drive_bit(par, gap);
    drive_bit(stp, gap);
  endtask

  task automatic test_reset;
    rst = 1'b1; sample_en = 1'b0; sdata = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++; if (sensor_input !== 4'd0) begin miss++; $display("FAIL reset_sensor_input got %0d exp 0", sensor_input); end
    vec++; if (sample_count !== 8'd0) begin miss++; $display("FAIL reset_count got %0d exp 0", sample_count); end
    vec++; if (sample_valid !== 1'b0) begin miss++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
    vec++; if (parity_err !== 1'b0) begin miss++; $display("FAIL reset_perr got %b exp 0", parity_err); end
    vec++; if (frame_err !== 1'b0) begin miss++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    $display("reset: sensor_input=%0d count=%0d", sensor_input, sample_count);
  endtask

  task automatic test_single;
    int v0;
    v0 = valid_seen;
    send_frame(4'b0110, 1'b0, 1'b1, 0);
    // Now one cycle after the stop tick.
    vec++; if (sample_valid !== 1'b1) begin miss++; $display("FAIL single_valid got %b exp 1", sample_valid); end
    vec++; if (sensor_input !== 4'd6) begin miss++; $display("FAIL single_data got %0d exp 6", sensor_input); end
    vec++; if (sample_count !== 8'd1) begin miss++; $display("FAIL single_count got %0d exp 1", sample_count); end
    vec++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin miss++; $display("FAIL single_errs got p=%b f=%b exp 0 0", parity_err, frame_err); end
    sdata = 1'b1;
    @(negedge clk);
    vec++; if (sample_valid !== 1'b0) begin miss++; $display("FAIL single_pulse_width got %b exp 0", sample_valid); end
    vec++; if (valid_seen - v0 !== 1) begin miss++; $display("FAIL single_pulses got %0d exp 1", valid_seen - v0); end
    $display("single: frame 0110 -> sensor_input=%0d count=%0d", sensor_input, sample_count);
  endtask

  task automatic test_parity_err;
    int v0;
    int p0;
    v0 = valid_seen; p0 = perr_seen;
    send_frame(4'b1101, 1'b0, 1'b1, 0);
    vec++; if (parity_err !== 1'b1) begin miss++; $display("FAIL perr_pulse got %b exp 1", parity_err); end
    vec++; if (frame_err !== 1'b0 || sample_valid !== 1'b0) begin miss++; $display("FAIL perr_others got f=%b v=%b exp 0 0", frame_err, sample_valid); end
    vec++; if (sensor_input !== 4'd6) begin miss++; $display("FAIL perr_hold got %0d exp 6", sensor_input); end
    vec++; if (sample_count !== 8'd1) begin miss++; $display("FAIL perr_count got %0d exp 1", sample_count); end
    sdata = 1'b1;
    @(negedge clk);
    vec++; if (perr_seen - p0 !== 1 || valid_seen !== v0) begin miss++; $display("FAIL perr_pulses got p=%0d v=%0d exp 1 0", perr_seen - p0, valid_seen - v0); end
    $display("parity: frame 1101 p=0 -> parity_err, sensor_input=%0d count=%0d", sensor_input, sample_count);
  endtask

  task automatic test_back_to_back;
    logic [3:0] dat [4];
    logic       par [4];
    int v0;
    dat[0] = 4'd13; par[0] = 1'b1;
    dat[1] = 4'd10; par[1] = 1'b0;
    dat[2] = 4'd3;  par[2] = 1'b0;
    dat[3] = 4'd9;  par[3] = 1'b0;
    v0 = valid_seen;
    for (int f = 0; f < 4; f++) begin
      send_frame(dat[f], par[f], 1'b1, 3);
      vec++; if (sensor_input !== dat[f]) begin miss++; $display("FAIL b2b_data%0d got %0d exp %0d", f, sensor_input, dat[f]); end
      vec++; if (sample_count !== 8'(2 + f)) begin miss++; $display("FAIL b2b_count%0d got %0d exp %0d", f, sample_count, 2 + f); end
      $display("b2b: frame %0d -> sensor_input=%0d count=%0d", f, sensor_input, sample_count);
    end
    sdata = 1'b1;
    vec++; if (valid_seen - v0 !== 4) begin miss++; $display("FAIL b2b_pulses got %0d exp 4", valid_seen - v0); end
  endtask

  task automatic test_frame_err;
    int f0;
    int p0;
    f0 = ferr_seen; p0 = perr_seen;
    // Bad stop and bad parity together: only frame_err may fire.
    send_frame(4'b1101, 1'b0, 1'b0, 0);
    vec++; if (frame_err !== 1'b1 || parity_err !== 1'b0) begin miss++; $display("FAIL ferr_priority got f=%b p=%b exp 1 0", frame_err, parity_err); end
    send_frame(4'b0110, 1'b0, 1'b0, 0);
    vec++; if (frame_err !== 1'b1 || sample_valid !== 1'b0) begin miss++; $display("FAIL ferr_pulse got f=%b v=%b exp 1 0", frame_err, sample_valid); end
    vec++; if (sensor_input !== 4'd9 || sample_count !== 8'd5) begin miss++; $display("FAIL ferr_hold got d=%0d c=%0d exp 9 5", sensor_input, sample_count); end
    // sdata is already 0: start bit on the very next tick.
    send_frame(4'b1001, 1'b0, 1'b1, 0);
    vec++; if (sample_valid !== 1'b1 || sensor_input !== 4'd9) begin miss++; $display("FAIL ferr_next_good got v=%b d=%0d exp 1 9", sample_valid, sensor_input); end
    vec++; if (sample_count !== 8'd6) begin miss++; $display("FAIL ferr_next_count got %0d exp 6", sample_count); end
    sdata = 1'b1;
    @(negedge clk);
    vec++; if (ferr_seen - f0 !== 2 || perr_seen !== p0) begin miss++; $display("FAIL ferr_pulses got f=%0d p=%0d exp 2 0", ferr_seen - f0, perr_seen - p0); end
    $display("frame_err: two bad stops then 1001 -> sensor_input=%0d count=%0d", sensor_input, sample_count);
  endtask

  task automatic test_reset_mid;
    drive_bit(1'b0, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b0, 0);
    // Reset together with a tick: reset must win.
    rst = 1'b1; sample_en = 1'b1; sdata = 1'b1;
    @(negedge clk);
    rst = 1'b0; sample_en = 1'b0;
    vec++; if (sensor_input !== 4'd0 || sample_count !== 8'd0) begin miss++; $display("FAIL midrst_outs got d=%0d c=%0d exp 0 0", sensor_input, sample_count); end
    vec++; if (sample_valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin miss++; $display("FAIL midrst_strobes got %b%b%b exp 000", sample_valid, parity_err, frame_err); end
    send_frame(4'b0011, 1'b0, 1'b1, 0);
    vec++; if (sensor_input !== 4'd3 || sample_count !== 8'd1 || sample_valid !== 1'b1) begin miss++; $display("FAIL midrst_frame got d=%0d c=%0d v=%b exp 3 1 1", sensor_input, sample_count, sample_valid); end
    sdata = 1'b1;
    @(negedge clk);
    $display("reset_mid: then 0011 -> sensor_input=%0d count=%0d", sensor_input, sample_count);
  endtask

  task automatic test_wrap;
    logic [3:0] d;
    for (int i = 0; i < 254; i++) begin
      d = 4'(i);
      send_frame(d, ^d, 1'b1, 0);
    end
    vec++; if (sample_count !== 8'd255) begin miss++; $display("FAIL wrap_pre got %0d exp 255", sample_count); end
    vec++; if (sensor_input !== 4'd13) begin miss++; $display("FAIL wrap_pre_data got %0d exp 13", sensor_input); end
    send_frame(4'b0101, 1'b0, 1'b1, 0);
    vec++; if (sample_count !== 8'd0 || sample_valid !== 1'b1) begin miss++; $display("FAIL wrap got c=%0d v=%b exp 0 1", sample_count, sample_valid); end
    vec++; if (sensor_input !== 4'd5) begin miss++; $display("FAIL wrap_data got %0d exp 5", sensor_input); end
    sdata = 1'b1;
    @(negedge clk);
    $display("wrap: count=%0d after 256 good frames since reset", sample_count);
  endtask

  initial begin
    vec = 0; miss = 0;
    valid_seen = 0; perr_seen = 0; ferr_seen = 0; multi_seen = 0;
    rst = 1'b1; sample_en = 1'b0; sdata = 1'b1;
    test_reset();
    test_single();
    test_parity_err();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    test_wrap();
    vec++; if (multi_seen !== 0) begin miss++; $display("FAIL strobe_exclusive got %0d overlapping cycles exp 0", multi_seen); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
